// File: rtl/if_stage_prefetch.sv
// if_stage_prefetch: multi-outstanding instruction fetch with an in-order buffer in front of decode
module if_stage_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  input  logic [31:0] ws_to_fs_bus,
  input  logic        fs_flush_pipe,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int PQ = 2 ** PW;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        halt_q, halt_d;
  logic [OW-1:0] outst_q, outst_d, cancel_q, cancel_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [64:0] mem_q [FIFO_DEPTH];
  logic [64:0] mem_d [FIFO_DEPTH];
  logic [31:0] pq_q [PQ];
  logic [31:0] pq_d [PQ];

  logic        redirect, aligned, req, hs, full, empty, valid, pop, drop;
  logic        push_data, push_adef, push;
  logic [31:0] target, used;
  logic [64:0] entry;

  assign redirect  = fs_flush_pipe | br_bus[32];
  assign target    = fs_flush_pipe ? ws_to_fs_bus : br_bus[31:0];
  // In-flight requests that will still land in the buffer reserve a slot, so a live push never finds it full
  assign used      = 32'(count_q) + 32'(outst_q) - 32'(cancel_q);
  assign aligned   = fetch_pc_q[1:0] == 2'b00;
  assign req       = resetn && !redirect && !halt_q && aligned && 32'(outst_q) < MAX_OUTST && used < FIFO_DEPTH;
  assign hs        = req & inst_sram_addr_ok;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign empty     = count_q == '0;
  assign valid     = !empty && !redirect;
  assign pop       = valid & ds_allowin;
  assign drop      = cancel_q != '0;
  assign push_data = inst_sram_data_ok && !drop && !redirect;
  // Misaligned PC is reported only once every older fetch has been delivered or discarded, keeping order
  assign push_adef = !redirect && !halt_q && !aligned && outst_q == cancel_q && !full;
  assign push      = push_data | push_adef;
  assign entry     = push_adef ? {1'b1, 32'h0, fetch_pc_q} : {1'b0, inst_sram_rdata, pq_q[pq_rd_q]};

  // Next-state for fetch PC, in-flight/cancel credits, PC-tag queue and instruction buffer
  always_comb begin
    fetch_pc_d = redirect ? target : hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    halt_d     = !redirect && (halt_q || push_adef);
    outst_d    = outst_q + OW'(hs) - OW'(inst_sram_data_ok);
    cancel_d   = redirect ? outst_q - OW'(inst_sram_data_ok) : cancel_q - OW'(inst_sram_data_ok && drop);
    pq_wr_d    = pq_wr_q + PW'(hs);
    pq_rd_d    = pq_rd_q + PW'(inst_sram_data_ok);
    pq_d       = pq_q;
    if (hs) pq_d[pq_wr_q] = fetch_pc_q;
    mem_d      = mem_q;
    if (push) mem_d[wr_q] = entry;
    rd_d       = redirect ? '0 : rd_q + FW'(pop);
    wr_d       = redirect ? '0 : wr_q + FW'(push);
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      halt_q     <= 1'b0;
      outst_q    <= '0;
      cancel_q   <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      pq_rd_q    <= '0;
      pq_wr_q    <= '0;
      mem_q      <= '{default: '0};
      pq_q       <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halt_q     <= halt_d;
      outst_q    <= outst_d;
      cancel_q   <= cancel_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pq_rd_q    <= pq_rd_d;
      pq_wr_q    <= pq_wr_d;
      mem_q      <= mem_d;
      pq_q       <= pq_d;
    end
  end

  assign fs_to_ds_valid  = valid;
  assign fs_to_ds_bus    = mem_q[rd_q];
  assign inst_sram_req   = req;
  assign inst_sram_addr  = resetn ? fetch_pc_q : 32'h0;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb_if_stage_prefetch: directed + random fetch traffic checked against a queue-level model
module tb_if_stage_prefetch;
  localparam logic [31:0] RPC = 32'h1c000000;
  localparam int FD = 4;
  localparam int MO = 2;

  logic        clk = 1'b0, resetn = 1'b0, ds_allowin = 1'b0, fs_flush_pipe = 1'b0;
  logic [32:0] br_bus = '0;
  logic [31:0] ws_to_fs_bus = '0;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  int checks = 0, errors = 0;
  int cyc = 0, dmin = 1, dmax = 1, ok_pct = 100;

  always #5 clk = ~clk;

  if_stage_prefetch #(.RESET_PC(RPC), .FIFO_DEPTH(FD), .MAX_OUTST(MO)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .ws_to_fs_bus(ws_to_fs_bus), .fs_flush_pipe(fs_flush_pipe),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  // Reference model: fetches in flight (dead = response to be discarded) and the decode buffer
  typedef struct { logic [31:0] pc; bit dead; } fly_t;
  typedef struct { logic [31:0] addr; int rdy; } pend_t;
  fly_t        fly[$];
  logic [64:0] fifo[$];
  logic [31:0] m_pc;
  bit          m_halt;
  pend_t       pend[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5a5a0f0f ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    fly.delete(); fifo.delete(); pend.delete();
    m_pc = RPC; m_halt = 0;
  endtask

  task automatic step(input bit allow = 1'b1, input bit br = 1'b0, input logic [31:0] bt = 32'h0,
                      input bit fl = 1'b0, input logic [31:0] ws = 32'h0);
    int nd, r;
    bit redir, ereq, ev, hs, dok, pop, adef;
    logic [31:0] tgt;
    fly_t f;
    @(negedge clk);
    cyc++;
    ds_allowin = allow; br_bus = {br, bt}; fs_flush_pipe = fl; ws_to_fs_bus = ws;
    dok = pend.size() > 0 && pend[0].rdy <= cyc;
    inst_sram_data_ok = dok;
    inst_sram_rdata = dok ? mem(pend[0].addr) : $urandom;
    inst_sram_addr_ok = $urandom_range(99) < ok_pct;
    #1;
    nd = 0;
    foreach (fly[i]) nd += int'(fly[i].dead);
    redir = fl | br;
    tgt = fl ? ws : bt;
    ereq = !redir && !m_halt && m_pc[1:0] == 2'b00 && fly.size() < MO && fifo.size() + fly.size() - nd < FD;
    ev = fifo.size() > 0 && !redir;
    chk("req", 65'(inst_sram_req), 65'(ereq));
    if (ereq) chk("addr", 65'(inst_sram_addr), 65'(m_pc));
    chk("valid", 65'(fs_to_ds_valid), 65'(ev));
    if (ev) chk("bus", fs_to_ds_bus, fifo[0]);
    // SRAM side: accept, then answer in order after a random delay
    if (dok) void'(pend.pop_front());
    if (inst_sram_req && inst_sram_addr_ok) begin
      r = cyc + int'($urandom_range(dmax, dmin));
      if (pend.size() > 0 && r < pend[$].rdy) r = pend[$].rdy;
      pend.push_back('{inst_sram_addr, r});
    end
    // Model update for the coming clock edge
    hs = ereq && inst_sram_addr_ok;
    pop = ev && allow;
    adef = !redir && !m_halt && m_pc[1:0] != 2'b00 && nd == fly.size() && fifo.size() < FD;
    if (pop) void'(fifo.pop_front());
    if (dok && fly.size() > 0) begin
      f = fly.pop_front();
      if (!f.dead && !redir) fifo.push_back({1'b0, inst_sram_rdata, f.pc});
    end
    if (adef) begin fifo.push_back({1'b1, 32'h0, m_pc}); m_halt = 1; end
    if (hs) begin fly.push_back('{m_pc, 1'b0}); m_pc += 32'd4; end
    if (redir) begin
      fifo.delete();
      foreach (fly[i]) fly[i].dead = 1;
      m_pc = tgt; m_halt = 0;
    end
  endtask

  task automatic wait_bus(input string tag, input logic [64:0] exp, input int n);
    bit found = 0;
    for (int i = 0; i < n && !found; i++) begin
      step();
      if (fs_to_ds_valid) begin found = 1; chk(tag, fs_to_ds_bus, exp); end
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_valid expected=%h", tag, exp);
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_req"}, 65'(inst_sram_req), 65'(0));
    chk({tag, "_addr"}, 65'(inst_sram_addr), 65'(0));
    chk({tag, "_valid"}, 65'(fs_to_ds_valid), 65'(0));
    chk({tag, "_bus"}, fs_to_ds_bus, 65'(0));
  endtask

  task automatic release_reset();
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0;
    br_bus = '0; fs_flush_pipe = 0; ds_allowin = 0;
    mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #1;
    reset_outputs("rst");
    chk("wr", 65'(inst_sram_wr), 65'(0));
    chk("size", 65'(inst_sram_size), 65'(2));
    chk("wstrb", 65'(inst_sram_wstrb), 65'(0));
    chk("wdata", 65'(inst_sram_wdata), 65'(0));
    release_reset();
    // Zero-wait streaming
    step();
    chk("first_addr", 65'(inst_sram_addr), 65'(RPC));
    repeat (12) step();
    // Decode stall fills the buffer, then drains in order
    repeat (10) step(1'b0);
    chk("stall_req", 65'(inst_sram_req), 65'(0));
    repeat (15) step();
    // Slow SRAM, branch with two fetches in flight
    dmin = 3; dmax = 3;
    repeat (6) step();
    step(1'b1, 1'b1, 32'h1c000100);
    wait_bus("br_pc", {1'b0, mem(32'h1c000100), 32'h1c000100}, 20);
    // Flush wins over simultaneous branch
    dmin = 1; dmax = 1;
    repeat (4) step();
    step(1'b1, 1'b1, 32'h1c000200, 1'b1, 32'h1c008000);
    chk("flush_valid", 65'(fs_to_ds_valid), 65'(0));
    wait_bus("flush_pc", {1'b0, mem(32'h1c008000), 32'h1c008000}, 20);
    // Misaligned branch target reports ADEF and halts until the next redirect
    repeat (3) step();
    step(1'b1, 1'b1, 32'h1c000102);
    wait_bus("adef", {1'b1, 32'h0, 32'h1c000102}, 20);
    repeat (5) step();
    chk("halt_req", 65'(inst_sram_req), 65'(0));
    step(1'b1, 1'b1, 32'h1c000200);
    wait_bus("restart_pc", {1'b0, mem(32'h1c000200), 32'h1c000200}, 20);
    // Reset in the middle of traffic
    dmin = 3; dmax = 3;
    repeat (4) step(1'b0);
    resetn = 1'b0;
    inst_sram_data_ok = 0; br_bus = '0; fs_flush_pipe = 0;
    #1;
    reset_outputs("midrst");
    release_reset();
    dmin = 1; dmax = 1;
    step();
    chk("rst_addr", 65'(inst_sram_addr), 65'(RPC));
    wait_bus("rst_pc", {1'b0, mem(RPC), RPC}, 10);
    // Random traffic
    dmin = 1; dmax = 4; ok_pct = 70;
    for (int i = 0; i < 800; i++) begin
      int k;
      logic [31:0] t;
      k = int'($urandom_range(99));
      t = RPC + 32'($urandom_range(255)) * 32'd4;
      if (k < 1) t = t + 32'($urandom_range(3, 1));
      step($urandom_range(99) < 75, k < 6, t, k >= 6 && k < 9, t + 32'h00008000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
